// File: rtl/cfo_nco_derotator.sv
// NCO and complex derotator: phase accumulator driven by the CFO loop frequency word,
// quarter-wave sin/cos LUT, and a 4-stage multiply-by-e^(-j*theta) pipeline.
module cfo_nco_derotator #(
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int AMP_WIDTH   = 16,
  parameter int LUT_ADDR    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freq_valid_i,
  input  logic [PHASE_WIDTH-1:0]        freq_word_i,
  input  logic                          din_valid_i,
  input  logic signed [DATA_WIDTH-1:0]  din_i_i,
  input  logic signed [DATA_WIDTH-1:0]  din_q_i,
  output logic                          dout_valid_o,
  output logic signed [DATA_WIDTH-1:0]  dout_i_o,
  output logic signed [DATA_WIDTH-1:0]  dout_q_o,
  output logic [PHASE_WIDTH-1:0]        phase_o
);

  localparam int FW       = LUT_ADDR - 2;
  localparam int LUT_SIZE = 2 ** FW;
  localparam int PROD_W   = DATA_WIDTH + AMP_WIDTH;
  localparam int SUM_W    = PROD_W + 1;
  localparam int SHIFT    = AMP_WIDTH - 1;

  localparam logic signed [SUM_W-1:0] C_ROUND = SUM_W'(2 ** (AMP_WIDTH - 2));
  localparam logic signed [SUM_W-1:0] C_MAX   = SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN   = ~C_MAX;

  // Elaboration-time sine evaluated at the centre of each table bin.
  function automatic logic signed [AMP_WIDTH-1:0] lut_entry(input int k);
    real x;
    real term;
    real s;
    x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** LUT_ADDR);
    term = x;
    s    = x;
    for (int n = 1; n < 20; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return AMP_WIDTH'($rtoi(s * real'(2 ** (AMP_WIDTH - 1) - 1) + 0.5));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
    logic signed [DATA_WIDTH-1:0] res;
    if (v > C_MAX) begin
      res = C_MAX[DATA_WIDTH-1:0];
    end else if (v < C_MIN) begin
      res = C_MIN[DATA_WIDTH-1:0];
    end else begin
      res = v[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  logic signed [AMP_WIDTH-1:0] w_rom [0:LUT_SIZE-1];

  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
    localparam logic signed [AMP_WIDTH-1:0] C_VAL = lut_entry(g);
    assign w_rom[g] = C_VAL;
  end

  logic [PHASE_WIDTH-1:0]       r_acc;
  logic [PHASE_WIDTH-1:0]       r_freq;
  logic [PHASE_WIDTH-1:0]       w_freq_eff;

  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_i;
  logic signed [DATA_WIDTH-1:0] r_s1_q;
  logic [PHASE_WIDTH-1:0]       r_s1_phase;
  logic [1:0]                   r_s1_quad;
  logic [FW-1:0]                r_s1_addr;

  logic [FW-1:0]                w_addr_rev;
  logic signed [AMP_WIDTH-1:0]  w_t_fwd;
  logic signed [AMP_WIDTH-1:0]  w_t_rev;
  logic signed [AMP_WIDTH-1:0]  w_sin;
  logic signed [AMP_WIDTH-1:0]  w_cos;

  logic                         r_s2_valid;
  logic signed [DATA_WIDTH-1:0] r_s2_i;
  logic signed [DATA_WIDTH-1:0] r_s2_q;
  logic [PHASE_WIDTH-1:0]       r_s2_phase;
  logic signed [AMP_WIDTH-1:0]  r_s2_sin;
  logic signed [AMP_WIDTH-1:0]  r_s2_cos;

  logic                         r_s3_valid;
  logic [PHASE_WIDTH-1:0]       r_s3_phase;
  logic signed [PROD_W-1:0]     r_s3_ic;
  logic signed [PROD_W-1:0]     r_s3_qs;
  logic signed [PROD_W-1:0]     r_s3_qc;
  logic signed [PROD_W-1:0]     r_s3_is;

  logic signed [SUM_W-1:0]      w_sum_i;
  logic signed [SUM_W-1:0]      w_sum_q;
  logic signed [SUM_W-1:0]      w_shr_i;
  logic signed [SUM_W-1:0]      w_shr_q;

  // A word arriving with a sample only affects the increment applied after it.
  assign w_freq_eff = freq_valid_i ? freq_word_i : r_freq;

  // Frequency register and phase accumulator; the accumulator moves only on samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_freq <= '0;
      r_acc  <= '0;
    end else begin
      if (freq_valid_i) begin
        r_freq <= freq_word_i;
      end
      if (din_valid_i) begin
        r_acc <= r_acc + w_freq_eff;
      end
    end
  end

  // S1: capture sample, phase and table address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_i     <= '0;
      r_s1_q     <= '0;
      r_s1_phase <= '0;
      r_s1_quad  <= 2'd0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= din_valid_i;
      if (din_valid_i) begin
        r_s1_i     <= din_i_i;
        r_s1_q     <= din_q_i;
        r_s1_phase <= r_acc;
        r_s1_quad  <= r_acc[PHASE_WIDTH-1 -: 2];
        r_s1_addr  <= r_acc[PHASE_WIDTH-3 -: FW];
      end
    end
  end

  assign w_addr_rev = ~r_s1_addr;
  assign w_t_fwd    = w_rom[r_s1_addr];
  assign w_t_rev    = w_rom[w_addr_rev];

  // Quadrant folding of the quarter-wave table into full-turn sin/cos.
  always_comb begin
    w_sin = w_t_fwd;
    w_cos = w_t_rev;
    case (r_s1_quad)
      2'd0: begin
        w_sin = w_t_fwd;
        w_cos = w_t_rev;
      end
      2'd1: begin
        w_sin = w_t_rev;
        w_cos = -w_t_fwd;
      end
      2'd2: begin
        w_sin = -w_t_fwd;
        w_cos = -w_t_rev;
      end
      default: begin
        w_sin = -w_t_rev;
        w_cos = w_t_fwd;
      end
    endcase
  end

  // S2: registered LUT read with sign applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_i     <= '0;
      r_s2_q     <= '0;
      r_s2_phase <= '0;
      r_s2_sin   <= '0;
      r_s2_cos   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_i     <= r_s1_i;
        r_s2_q     <= r_s1_q;
        r_s2_phase <= r_s1_phase;
        r_s2_sin   <= w_sin;
        r_s2_cos   <= w_cos;
      end
    end
  end

  // S3: four full-precision products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_phase <= '0;
      r_s3_ic    <= '0;
      r_s3_qs    <= '0;
      r_s3_qc    <= '0;
      r_s3_is    <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_phase <= r_s2_phase;
        r_s3_ic    <= PROD_W'(r_s2_i) * PROD_W'(r_s2_cos);
        r_s3_qs    <= PROD_W'(r_s2_q) * PROD_W'(r_s2_sin);
        r_s3_qc    <= PROD_W'(r_s2_q) * PROD_W'(r_s2_cos);
        r_s3_is    <= PROD_W'(r_s2_i) * PROD_W'(r_s2_sin);
      end
    end
  end

  // Multiplying by e^(-j*theta): yI = I*cos + Q*sin, yQ = Q*cos - I*sin, round half up.
  assign w_sum_i = SUM_W'(r_s3_ic) + SUM_W'(r_s3_qs) + C_ROUND;
  assign w_sum_q = SUM_W'(r_s3_qc) - SUM_W'(r_s3_is) + C_ROUND;
  assign w_shr_i = w_sum_i >>> SHIFT;
  assign w_shr_q = w_sum_q >>> SHIFT;

  // S4: saturate into the output registers, which hold between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_o <= 1'b0;
      dout_i_o     <= '0;
      dout_q_o     <= '0;
      phase_o      <= '0;
    end else begin
      dout_valid_o <= r_s3_valid;
      if (r_s3_valid) begin
        dout_i_o <= sat(w_shr_i);
        dout_q_o <= sat(w_shr_q);
        phase_o  <= r_s3_phase;
      end
    end
  end

endmodule

// File: tb/tb_cfo_nco_derotator.sv
// Randomized and directed check of cfo_nco_derotator against a cycle-stamped
// behavioural model computed from real-valued sine and plain integer arithmetic.
module tb_cfo_nco_derotator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               freq_valid_i = 1'b0;
  logic [31:0]        freq_word_i = 32'd0;
  logic               din_valid_i = 1'b0;
  logic signed [15:0] din_i_i = 16'sd0;
  logic signed [15:0] din_q_i = 16'sd0;
  logic               dout_valid_o;
  logic signed [15:0] dout_i_o;
  logic signed [15:0] dout_q_o;
  logic [31:0]        phase_o;

  cfo_nco_derotator dut (
    .clk          (clk),
    .rst          (rst),
    .freq_valid_i (freq_valid_i),
    .freq_word_i  (freq_word_i),
    .din_valid_i  (din_valid_i),
    .din_i_i      (din_i_i),
    .din_q_i      (din_q_i),
    .dout_valid_o (dout_valid_o),
    .dout_i_o     (dout_i_o),
    .dout_q_o     (dout_q_o),
    .phase_o      (phase_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          i;
    int          q;
    logic [31:0] ph;
  } exp_t;

  typedef struct {
    int          cyc;
    int          i;
    int          q;
    logic [31:0] ph;
  } obs_t;

  int          tbl [256];
  exp_t        exq[$];
  obs_t        obs[$];
  int          cyc = 0;
  bit          armed = 1'b0;
  int          h_i = 0;
  int          h_q = 0;
  logic [31:0] h_ph = 32'd0;
  logic [31:0] m_acc = 32'd0;
  logic [31:0] m_freq = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return int'(v);
  endfunction

  // e^(-j*theta) applied to (i,q) using the folded quarter-wave table.
  function automatic void mdl(input logic [31:0] th, input int i, input int q,
                              output int yi, output int yq);
    int     qd;
    int     f;
    int     s;
    int     c;
    longint a;
    longint b;
    qd = int'(th[31:30]);
    f  = int'(th[29:22]);
    case (qd)
      0:       begin s =  tbl[f];     c =  tbl[255-f]; end
      1:       begin s =  tbl[255-f]; c = -tbl[f];     end
      2:       begin s = -tbl[f];     c = -tbl[255-f]; end
      default: begin s = -tbl[255-f]; c =  tbl[f];     end
    endcase
    a  = longint'(i) * c + longint'(q) * s;
    b  = longint'(q) * c - longint'(i) * s;
    yi = clamp16((a + 16384) >>> 15);
    yq = clamp16((b + 16384) >>> 15);
  endfunction

  // Model: consumes inputs at each rising edge and schedules the output 3 edges later.
  initial begin
    int yi;
    int yq;
    logic [31:0] feff;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_acc = 32'd0;
        m_freq = 32'd0;
        exq.delete();
        h_i = 0;
        h_q = 0;
        h_ph = 32'd0;
        armed = 1'b1;
      end else begin
        feff = freq_valid_i ? freq_word_i : m_freq;
        if (freq_valid_i) m_freq = freq_word_i;
        if (din_valid_i) begin
          mdl(m_acc, int'(din_i_i), int'(din_q_i), yi, yq);
          exq.push_back('{due: cyc + 3, i: yi, q: yq, ph: m_acc});
          m_acc = m_acc + feff;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    exp_t e;
    bit   expv;
    forever begin
      @(negedge clk);
      if (armed) begin
        expv = 1'b0;
        if (exq.size() > 0 && exq[0].due == cyc) begin
          e = exq.pop_front();
          h_i = e.i;
          h_q = e.q;
          h_ph = e.ph;
          expv = 1'b1;
        end
        chk("dout_valid", 32'(dout_valid_o), 32'(expv));
        chk("dout_i", 32'(int'(dout_i_o)), 32'(h_i));
        chk("dout_q", 32'(int'(dout_q_o)), 32'(h_q));
        chk("phase", phase_o, h_ph);
        if (dout_valid_o) obs.push_back('{cyc: cyc, i: int'(dout_i_o), q: int'(dout_q_o), ph: phase_o});
      end
    end
  end

  task automatic drive(input logic r, input logic fv, input logic [31:0] fw,
                       input logic dv, input int di, input int dq);
    @(posedge clk);
    #1;
    rst = r;
    freq_valid_i = fv;
    freq_word_i = fw;
    din_valid_i = dv;
    din_i_i = 16'(di);
    din_q_i = 16'(dq);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'd0, 1'b0, 0, 0);
  endtask

  initial begin
    int yi;
    int yq;
    int t0;
    int ei [4];
    int eq [4];

    for (int k = 0; k < 256; k++)
      tbl[k] = $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) / 1024.0) + 0.5);

    // Hand-derived model pins.
    mdl(32'h0000_0000, 1000, 0, yi, yq);
    chk("pin_q0_i", 32'(yi), 32'(1000));
    chk("pin_q0_q", 32'(yq), 32'(-3));
    mdl(32'h4000_0000, 1000, 0, yi, yq);
    chk("pin_q1_i", 32'(yi), 32'(-3));
    chk("pin_q1_q", 32'(yq), 32'(-1000));
    mdl(32'h8000_0000, 1000, 0, yi, yq);
    chk("pin_q2_i", 32'(yi), 32'(-1000));
    chk("pin_q2_q", 32'(yq), 32'(3));
    mdl(32'hC000_0000, 1000, 0, yi, yq);
    chk("pin_q3_i", 32'(yi), 32'(3));
    chk("pin_q3_q", 32'(yq), 32'(1000));

    // Identity and latency.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    obs.delete();
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1000, 0);
    t0 = cyc;
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 32'd0, 1'b1, 1000, 0);
    idle(6);
    chk("ident_count", 32'(obs.size()), 32'd8);
    if (obs.size() > 0) chk("ident_latency", 32'(obs[0].cyc - t0), 32'd4);
    foreach (obs[k]) begin
      chk("ident_i", 32'(obs[k].i), 32'(1000));
      chk("ident_q", 32'(obs[k].q), 32'(-3));
      chk("ident_ph", obs[k].ph, 32'd0);
    end

    // Quarter-turn rotation.
    ei = '{1000, -3, -1000, 3};
    eq = '{-3, -1000, 3, 1000};
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    obs.delete();
    drive(1'b0, 1'b1, 32'h4000_0000, 1'b1, 1000, 0);
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 32'd0, 1'b1, 1000, 0);
    idle(6);
    chk("quarter_count", 32'(obs.size()), 32'd8);
    foreach (obs[k]) begin
      chk("quarter_i", 32'(obs[k].i), 32'(ei[k % 4]));
      chk("quarter_q", 32'(obs[k].q), 32'(eq[k % 4]));
      chk("quarter_ph", obs[k].ph, 32'h4000_0000 * 32'(k % 4));
    end

    // Half-turn wrap.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    obs.delete();
    drive(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1000, 0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 32'd0, 1'b1, 1000, 0);
    idle(6);
    chk("wrap_count", 32'(obs.size()), 32'd6);
    foreach (obs[k]) begin
      chk("wrap_ph", obs[k].ph, (k % 2 == 0) ? 32'h0 : 32'h8000_0000);
      chk("wrap_i", 32'(obs[k].i), (k % 2 == 0) ? 32'(1000) : 32'(-1000));
      chk("wrap_q", 32'(obs[k].q), (k % 2 == 0) ? 32'(-3) : 32'(3));
    end

    // Saturation at pi/4.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    obs.delete();
    drive(1'b0, 1'b1, 32'h2000_0000, 1'b1, -32768, -32768);
    drive(1'b0, 1'b0, 32'd0, 1'b1, -32768, -32768);
    idle(6);
    chk("sat_count", 32'(obs.size()), 32'd2);
    if (obs.size() > 1) begin
      chk("sat_i", 32'(obs[1].i), 32'(-32768));
      chk("sat_ph", obs[1].ph, 32'h2000_0000);
    end

    // Simultaneous frequency update with input gaps.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 32'h4000_0000, 1'b0, 0, 0);
    obs.delete();
    drive(1'b0, 1'b0, 32'd0, 1'b1, 500, 200);
    t0 = cyc;
    drive(1'b0, 1'b1, 32'h1000_0000, 1'b1, -700, 300);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1234, -4321);
    idle(7);
    chk("simul_count", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      chk("simul_ph0", obs[0].ph, 32'h0000_0000);
      chk("simul_ph1", obs[1].ph, 32'h4000_0000);
      chk("simul_ph2", obs[2].ph, 32'h5000_0000);
      chk("simul_cyc0", 32'(obs[0].cyc - t0), 32'd4);
      chk("simul_cyc1", 32'(obs[1].cyc - t0), 32'd5);
      chk("simul_cyc2", 32'(obs[2].cyc - t0), 32'd7);
    end

    // Reset with samples in flight; the input during reset is ignored.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 32'h4000_0000, 1'b1, 900, 100);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 900, 100);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 900, 100);
    obs.delete();
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 555, 555);
    idle(6);
    chk("midrst_quiet", 32'(obs.size()), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1000, 0);
    idle(6);
    chk("midrst_count", 32'(obs.size()), 32'd1);
    if (obs.size() == 1) begin
      chk("midrst_ph", obs[0].ph, 32'd0);
      chk("midrst_i", 32'(obs[0].i), 32'(1000));
    end

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      int di;
      int dq;
      di = int'($urandom_range(0, 65535)) - 32768;
      dq = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 9) == 0) di = -32768;
      if ($urandom_range(0, 9) == 0) dq = -32768;
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) != 0), di, dq);
    end
    idle(8);
    chk("drained", 32'(exq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
